lfsr_block_stream: RTL and testbench
====================================

# lfsr_block_stream

Parametrised Fibonacci-LFSR random source that emits a multi-block random number (default 4096 bits as 128 × 32-bit words) over a valid/ready stream. It is the successor of the fixed 32-bit generator feeding the big-number datapath. It adds:
- configurable width, taps and length;
- runtime seeding with lock-up protection;
- output back-pressure with stable data;
- optional forcing of the number's MSB and LSB, giving full-length, odd candidates.

## Interface
Parameters:
- WIDTH, 32: LFSR and output word width (≥ 8).
- TOTAL_BITS, 4096: bits per generated number. Must be a multiple of WIDTH, with TOTAL_BITS/WIDTH ≥ 2; elaboration-time assertion.
- TAPS, 32'h8020_0003: feedback mask, width WIDTH. Bit i set means state bit i enters the XOR.
- SEED, all ones: reset state, also the substitute for a zero seed.
- FORCE_LSB, 1: force bit 0 of the first word to 1.
- FORCE_MSB, 1: force bit WIDTH-1 of the last word to 1.

Ports:
- clk_in, input, 1: the single clock.
- rst_in, input, 1: reset; asynchronous, active-high.
- seed_in, input, WIDTH: seed value.
- seed_valid_in, input, 1: load seed_in; honoured in IDLE only.
- trigger_in, input, 1: request one number.
- ready_in, input, 1: downstream accepts the current word.
- rand_out, output, WIDTH: current word. Words are emitted least-significant first.
- valid_out, output, 1: rand_out holds a valid word.
- last_out, output, 1: the current word is word NUM_BLOCKS-1.
- busy_out, output, 1: high in STREAM.

## Operation
- NUM_BLOCKS = TOTAL_BITS/WIDTH. The beat counter is $clog2(NUM_BLOCKS) bits wide.
- LFSR steps every cycle (free-running), regardless of state:
  - next = {state[WIDTH-2:0], ^(state & TAPS)}.
- Seed load in IDLE: state <= (seed_in == 0) ? SEED : seed_in. The load replaces that cycle's step.
- FSM has two states:
  - IDLE → STREAM on trigger_in, unless seed_valid_in is also high. Seed wins; trigger is dropped.
  - STREAM → IDLE when the beat with last_out is accepted (valid_out & ready_in), unless trigger_in is high in that same cycle. In that case it stays in STREAM with the count reset to 0 (back-to-back numbers).
  - In STREAM, trigger_in is ignored except on the final accepted beat, and seed_valid_in is ignored.
- Output register:
  - Loaded with the masked current LFSR state on entry to STREAM and on every accepted non-final beat.
  - Held while valid_out & !ready_in.
- Masking:
  - Word 0 gets bit 0 forced when FORCE_LSB.
  - Word NUM_BLOCKS-1 gets bit WIDTH-1 forced when FORCE_MSB.
  - Masking applies to the output copy only, never to the LFSR state.
- last_out is high exactly when valid_out and count == NUM_BLOCKS-1.

## Timing
- Reset values:
  - state = SEED, FSM = IDLE, count = 0.
  - rand_out = 0, valid_out = 0, last_out = 0, busy_out = 0.
- Trigger accepted at edge t: valid_out, busy_out and word 0 appear after edge t. Word 0 = LFSR state sampled at edge t.
- Each accepted beat at edge t: the next word is the LFSR state sampled at edge t, visible after t.
- Full ready: one word per cycle, so NUM_BLOCKS cycles per number. Stalls extend this cycle for cycle.
- Final beat accepted without trigger: valid_out, last_out and busy_out are low in the next cycle.
- rst_in asserted mid-stream: all outputs return to their reset values asynchronously; the partial number is discarded.
- No combinational path from inputs to outputs.

## Structure
- Package lfsr_pkg holds:
  - the state enum {IDLE, STREAM};
  - the default-taps constant for 32 bits (32'h8020_0003);
  - a function computing the feedback bit.
- Sub-module lfsr_core (WIDTH, TAPS, SEED) contains the free-running shift register with load and zero-seed substitution. lfsr_block_stream owns the FSM, counter, mask and output register.

## Test plan
- Reset, then idle 1 cycle with default params: internal state FFFF_FFFF → FFFF_FFFE. All outputs 0.
- In IDLE, seed_in = 0000_0001: the next two states are 0000_0003 then 0000_0006. seed_in = 0 loads FFFF_FFFF.
- TOTAL_BITS = 128, ready_in = 1, one trigger:
  - exactly 4 words on consecutive cycles;
  - word 0 bit 0 = 1, word 3 bit 31 = 1;
  - last_out only on word 3;
  - valid_out low afterwards.
- Same config, ready_in low for 5 cycles after word 1: rand_out and last_out are stable throughout. The sequence resumes with word 2 and no word is lost or duplicated.
- trigger_in held high on the final handshake: valid_out stays high and word 0 of the next number follows immediately. A trigger mid-stream does not restart the count.
- rst_in pulsed at word 2: outputs are 0 immediately. A new trigger then reproduces the post-reset sequence from FFFF_FFFF.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the block-stream LFSR random source.
// Holds the FSM state encoding, default taps and the feedback reduction.
package lfsr_pkg;

   typedef enum logic {
      IDLE,
      STREAM
   } fsm_t;

   localparam logic [31:0] TAPS_32 = 32'h8020_0003;

   // Widest LFSR the feedback helper handles; narrower states are zero-extended.
   localparam int unsigned MAX_WIDTH = 64;

   function automatic logic feedback(input logic [MAX_WIDTH-1:0] state,
                                     input logic [MAX_WIDTH-1:0] taps);
      return ^(state & taps);
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with synchronous seed load.
// A zero seed is replaced by SEED so the register can never lock up.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int unsigned       WIDTH = 32,
   parameter logic [WIDTH-1:0] TAPS  = TAPS_32,
   parameter logic [WIDTH-1:0] SEED  = '1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] state_out
);

   logic [WIDTH-1:0] state_q;
   logic             fb;

   assign fb        = feedback(MAX_WIDTH'(state_q), MAX_WIDTH'(TAPS));
   assign state_out = state_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= SEED;
      end else if (load_in) begin
         state_q <= (seed_in == '0) ? SEED : seed_in;
      end else begin
         state_q <= {state_q[WIDTH-2:0], fb};
      end
   end

endmodule

// File: rtl/lfsr_block_stream.sv
// Multi-word random number source: streams NUM_BLOCKS LFSR words, LS word first,
// over valid/ready, optionally forcing the number's LSB and MSB to 1.
module lfsr_block_stream
   import lfsr_pkg::*;
#(
   parameter int unsigned       WIDTH      = 32,
   parameter int unsigned       TOTAL_BITS = 4096,
   parameter logic [WIDTH-1:0] TAPS       = TAPS_32,
   parameter logic [WIDTH-1:0] SEED       = '1,
   parameter bit                FORCE_LSB  = 1'b1,
   parameter bit                FORCE_MSB  = 1'b1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             seed_valid_in,
   input  logic             trigger_in,
   input  logic             ready_in,
   output logic [WIDTH-1:0] rand_out,
   output logic             valid_out,
   output logic             last_out,
   output logic             busy_out
);

   localparam int unsigned NUM_BLOCKS = TOTAL_BITS / WIDTH;
   localparam int unsigned CW         = $clog2(NUM_BLOCKS);
   localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BLOCKS - 1);

   if ((TOTAL_BITS % WIDTH) != 0 || NUM_BLOCKS < 2 || WIDTH < 8 || WIDTH > MAX_WIDTH) begin : g_param_check
      $error("lfsr_block_stream: illegal WIDTH/TOTAL_BITS combination");
   end

   fsm_t             fsm_q, fsm_nxt;
   logic [CW-1:0]    count_q, count_nxt;
   logic [WIDTH-1:0] word_q, word_nxt;
   logic [WIDTH-1:0] lfsr_state;
   logic             load_seed;

   function automatic logic [WIDTH-1:0] mask_word(input logic [WIDTH-1:0] w,
                                                  input logic [CW-1:0]    idx);
      logic [WIDTH-1:0] m;
      m = w;
      if (FORCE_LSB && idx == '0)     m[0]       = 1'b1;
      if (FORCE_MSB && idx == LAST_IDX) m[WIDTH-1] = 1'b1;
      return m;
   endfunction

   assign load_seed = (fsm_q == IDLE) && seed_valid_in;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .load_in   (load_seed),
      .seed_in   (seed_in),
      .state_out (lfsr_state)
   );

   // valid_out is exactly "in STREAM", so a beat is accepted whenever ready_in is high there.
   always_comb begin
      fsm_nxt   = fsm_q;
      count_nxt = count_q;
      word_nxt  = word_q;
      case (fsm_q)
         IDLE: begin
            if (trigger_in && !seed_valid_in) begin
               fsm_nxt   = STREAM;
               count_nxt = '0;
               word_nxt  = mask_word(lfsr_state, '0);
            end
         end
         STREAM: begin
            if (ready_in) begin
               if (count_q == LAST_IDX) begin
                  count_nxt = '0;
                  if (trigger_in) begin
                     word_nxt = mask_word(lfsr_state, '0);
                  end else begin
                     fsm_nxt = IDLE;
                  end
               end else begin
                  count_nxt = count_q + CW'(1);
                  word_nxt  = mask_word(lfsr_state, count_q + CW'(1));
               end
            end
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         fsm_q   <= IDLE;
         count_q <= '0;
         word_q  <= '0;
      end else begin
         fsm_q   <= fsm_nxt;
         count_q <= count_nxt;
         word_q  <= word_nxt;
      end
   end

   assign rand_out  = word_q;
   assign valid_out = (fsm_q == STREAM);
   assign busy_out  = (fsm_q == STREAM);
   assign last_out  = (fsm_q == STREAM) && (count_q == LAST_IDX);

endmodule

// File: tb/tb_lfsr_block_stream.sv
// Directed bench for lfsr_block_stream configured as 4 x 32-bit words.
module tb_lfsr_block_stream;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] seed_in;
   logic        seed_valid_in;
   logic        trigger_in;
   logic        ready_in;
   logic [31:0] rand_out;
   logic        valid_out;
   logic        last_out;
   logic        busy_out;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m;
   bit          m_idle;

   lfsr_block_stream #(
      .WIDTH      (32),
      .TOTAL_BITS (128),
      .TAPS       (32'h8020_0003),
      .SEED       (32'hFFFF_FFFF),
      .FORCE_LSB  (1'b1),
      .FORCE_MSB  (1'b1)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .seed_in       (seed_in),
      .seed_valid_in (seed_valid_in),
      .trigger_in    (trigger_in),
      .ready_in      (ready_in),
      .rand_out      (rand_out),
      .valid_out     (valid_out),
      .last_out      (last_out),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] step(input logic [31:0] s);
      return {s[30:0], ^(s & 32'h8020_0003)};
   endfunction

   // Advance one clock; the model LFSR follows the same edge.
   task automatic tick();
      logic [31:0] nx;
      nx = (m_idle && seed_valid_in) ? ((seed_in == 32'h0) ? 32'hFFFF_FFFF : seed_in) : step(m);
      @(posedge clk_in);
      m = nx;
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; seed_in = '0; seed_valid_in = 1'b0; trigger_in = 1'b0; ready_in = 1'b1;
      #2;
      total++;
      if ({rand_out, valid_out, last_out, busy_out} !== 35'h0) begin
         bad++; $display("FAIL reset_outputs got=%h/%b%b%b exp=0", rand_out, valid_out, last_out, busy_out);
      end
      total++;
      if (dut.u_core.state_q !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL reset_state got=%h exp=ffffffff", dut.u_core.state_q);
      end
      @(negedge clk_in);
      rst_in = 1'b0; m = 32'hFFFF_FFFF; m_idle = 1'b1;
      tick();
      total++;
      if (dut.u_core.state_q !== 32'hFFFF_FFFE) begin
         bad++; $display("FAIL idle_step got=%h exp=fffffffe", dut.u_core.state_q);
      end
      total++;
      if ({rand_out, valid_out, last_out, busy_out} !== 35'h0) begin
         bad++; $display("FAIL idle_outputs got=%h/%b%b%b exp=0", rand_out, valid_out, last_out, busy_out);
      end
   endtask

   task automatic test_seed();
      logic [31:0] exp_st [3];
      exp_st = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0006};
      m_idle = 1'b1;
      seed_in = 32'h0000_0001; seed_valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         seed_valid_in = 1'b0;
         total++;
         if (dut.u_core.state_q !== exp_st[i]) begin
            bad++; $display("FAIL seed_seq[%0d] got=%h exp=%h", i, dut.u_core.state_q, exp_st[i]);
         end
      end
      seed_in = 32'h0; seed_valid_in = 1'b1;
      tick();
      total++;
      if (dut.u_core.state_q !== 32'hFFFF_FFFF) begin
         bad++; $display("FAIL zero_seed got=%h exp=ffffffff", dut.u_core.state_q);
      end
      seed_in = 32'h1234_5678; trigger_in = 1'b1;
      tick();
      seed_valid_in = 1'b0; trigger_in = 1'b0;
      total++;
      if (dut.u_core.state_q !== 32'h1234_5678 || valid_out !== 1'b0 || busy_out !== 1'b0) begin
         bad++; $display("FAIL seed_beats_trigger got=%h v=%b b=%b exp=12345678 v=0 b=0",
                         dut.u_core.state_q, valid_out, busy_out);
      end
   endtask

   // Seed 1 then trigger: words are 1, 3, 6, 8000000D with full ready.
   task automatic test_stream();
      logic [31:0] exp_w [4];
      exp_w = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0006, 32'h8000_000D};
      ready_in = 1'b1; m_idle = 1'b1;
      seed_in = 32'h1; seed_valid_in = 1'b1;
      tick();
      seed_valid_in = 1'b0; trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0; m_idle = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            if (k == 2) begin seed_valid_in = 1'b1; seed_in = 32'h55; end
            tick();
            seed_valid_in = 1'b0;
         end
         total++;
         if (rand_out !== exp_w[k] || valid_out !== 1'b1 || busy_out !== 1'b1 || last_out !== (k == 3)) begin
            bad++; $display("FAIL stream_word[%0d] got=%h v=%b l=%b b=%b exp=%h v=1 l=%b b=1",
                            k, rand_out, valid_out, last_out, busy_out, exp_w[k], (k == 3));
         end
      end
      tick();
      m_idle = 1'b1;
      total++;
      if (valid_out !== 1'b0 || last_out !== 1'b0 || busy_out !== 1'b0) begin
         bad++; $display("FAIL stream_end got v=%b l=%b b=%b exp=000", valid_out, last_out, busy_out);
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp;
      ready_in = 1'b1; m_idle = 1'b1;
      seed_in = 32'h1; seed_valid_in = 1'b1;
      tick();
      seed_valid_in = 1'b0; trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0; m_idle = 1'b0;
      tick();
      total++;
      if (rand_out !== 32'h3 || last_out !== 1'b0) begin
         bad++; $display("FAIL stall_word1 got=%h l=%b exp=00000003 l=0", rand_out, last_out);
      end
      ready_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (rand_out !== 32'h3 || last_out !== 1'b0 || valid_out !== 1'b1) begin
            bad++; $display("FAIL stall_hold[%0d] got=%h v=%b l=%b exp=00000003 v=1 l=0",
                            i, rand_out, valid_out, last_out);
         end
      end
      ready_in = 1'b1;
      exp = m;
      tick();
      total++;
      if (rand_out !== exp || last_out !== 1'b0) begin
         bad++; $display("FAIL stall_word2 got=%h l=%b exp=%h l=0", rand_out, last_out, exp);
      end
      exp = m | 32'h8000_0000;
      tick();
      ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (rand_out !== exp || last_out !== 1'b1 || valid_out !== 1'b1) begin
            bad++; $display("FAIL stall_last[%0d] got=%h v=%b l=%b exp=%h v=1 l=1",
                            i, rand_out, valid_out, last_out, exp);
         end
         if (i < 2) tick();
      end
      ready_in = 1'b1;
      tick();
      m_idle = 1'b1;
      total++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
         bad++; $display("FAIL stall_end got v=%b b=%b exp=00", valid_out, busy_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4];
      logic [31:0] exp;
      exp_w = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0006, 32'h8000_000D};
      ready_in = 1'b1; m_idle = 1'b1;
      seed_in = 32'h1; seed_valid_in = 1'b1;
      tick();
      seed_valid_in = 1'b0; trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0; m_idle = 1'b0;
      for (int k = 1; k < 4; k++) begin
         trigger_in = (k == 2);
         tick();
         trigger_in = 1'b0;
         total++;
         if (rand_out !== exp_w[k] || last_out !== (k == 3)) begin
            bad++; $display("FAIL b2b_first[%0d] got=%h l=%b exp=%h l=%b",
                            k, rand_out, last_out, exp_w[k], (k == 3));
         end
      end
      for (int k = 0; k < 4; k++) begin
         exp = m;
         if (k == 0) exp[0] = 1'b1;
         if (k == 3) exp[31] = 1'b1;
         trigger_in = (k == 0);
         tick();
         trigger_in = 1'b0;
         total++;
         if (rand_out !== exp || valid_out !== 1'b1 || busy_out !== 1'b1 || last_out !== (k == 3)) begin
            bad++; $display("FAIL b2b_second[%0d] got=%h v=%b l=%b b=%b exp=%h v=1 l=%b b=1",
                            k, rand_out, valid_out, last_out, busy_out, exp, (k == 3));
         end
      end
      tick();
      m_idle = 1'b1;
      total++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0 || last_out !== 1'b0) begin
         bad++; $display("FAIL b2b_end got v=%b l=%b b=%b exp=000", valid_out, last_out, busy_out);
      end
   endtask

   // After reset the sequence from FFFFFFFF is FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFB.
   task automatic test_reset_mid();
      logic [31:0] exp_w [4];
      exp_w = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB};
      ready_in = 1'b1; m_idle = 1'b1;
      seed_in = 32'h1; seed_valid_in = 1'b1;
      tick();
      seed_valid_in = 1'b0; trigger_in = 1'b1;
      tick();
      trigger_in = 1'b0; m_idle = 1'b0;
      tick();
      tick();
      total++;
      if (rand_out !== 32'h6 || valid_out !== 1'b1) begin
         bad++; $display("FAIL pre_reset_word2 got=%h v=%b exp=00000006 v=1", rand_out, valid_out);
      end
      rst_in = 1'b1;
      #1;
      total++;
      if ({rand_out, valid_out, last_out, busy_out} !== 35'h0) begin
         bad++; $display("FAIL async_reset got=%h/%b%b%b exp=0", rand_out, valid_out, last_out, busy_out);
      end
      @(negedge clk_in);
      rst_in = 1'b0; m = 32'hFFFF_FFFF;
      trigger_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         trigger_in = 1'b0;
         total++;
         if (rand_out !== exp_w[k] || last_out !== (k == 3) || valid_out !== 1'b1) begin
            bad++; $display("FAIL post_reset_word[%0d] got=%h v=%b l=%b exp=%h v=1 l=%b",
                            k, rand_out, valid_out, last_out, exp_w[k], (k == 3));
         end
      end
      tick();
      m_idle = 1'b1;
      total++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
         bad++; $display("FAIL post_reset_end got v=%b b=%b exp=00", valid_out, busy_out);
      end
   endtask

   initial begin
      m = 32'hFFFF_FFFF;
      m_idle = 1'b1;
      test_reset();
      test_seed();
      test_stream();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
